// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2, K=3 convolutional encoder with valid/ready handshakes.
// Each frame is followed by two zero tail bits, so the trellis ends in S0,
// which is the state the matching Viterbi decoder starts from.
module conv_encoder_framed #(
  parameter int         LEN_WIDTH = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] frame_len_i,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  output logic                 bit_ready_o,
  output logic [1:0]           sym_o,
  output logic                 sym_valid_o,
  input  logic                 sym_ready_i,
  output logic                 sym_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           sreg;
  logic [LEN_WIDTH-1:0] bits_left;
  logic [1:0]           tail_cnt;
  logic                 can_load;
  logic                 bit_accept;

  // Symbol for input u from state s: {c0 (G0), c1 (G1)}; bit2=u, bit1=s[1], bit0=s[0].
  function automatic logic [1:0] encode(input logic u, input logic [1:0] s);
    logic [2:0] taps;
    taps = {u, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // Output slot is free when empty or being drained this cycle; bits are only taken in DATA.
  always_comb begin
    can_load    = !sym_valid_o || sym_ready_i;
    bit_ready_o = (state == DATA) && can_load;
    bit_accept  = bit_valid_i && bit_ready_o;
  end

  // Frame FSM, shift register and single-stage registered output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sreg        <= 2'b00;
      bits_left   <= '0;
      tail_cnt    <= 2'd0;
      sym_o       <= 2'b00;
      sym_valid_o <= 1'b0;
      sym_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (sym_valid_o && sym_ready_i) begin
        sym_valid_o <= 1'b0;
        sym_last_o  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            sreg      <= 2'b00;
            bits_left <= frame_len_i;
            tail_cnt  <= 2'd2;
            busy_o    <= 1'b1;
            state     <= (frame_len_i != '0) ? DATA : TAIL;
          end
        end
        DATA: begin
          if (bit_accept) begin
            sym_o       <= encode(bit_i, sreg);
            sym_valid_o <= 1'b1;
            sym_last_o  <= 1'b0;
            sreg        <= {bit_i, sreg[1]};
            bits_left   <= bits_left - LEN_WIDTH'(1);
            if (bits_left == LEN_WIDTH'(1)) begin
              tail_cnt <= 2'd2;
              state    <= TAIL;
            end
          end
        end
        TAIL: begin
          if (can_load) begin
            sym_o       <= encode(1'b0, sreg);
            sym_valid_o <= 1'b1;
            sym_last_o  <= (tail_cnt == 2'd1);
            sreg        <= {1'b0, sreg[1]};
            tail_cnt    <= tail_cnt - 2'd1;
            if (tail_cnt == 2'd1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (sym_valid_o && sym_ready_i && sym_last_o) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_encoder_framed.md
Name: conv_encoder_framed

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder (BMU/ACSU/PMU chain). The block accepts a framed stream of information bits over a valid/ready handshake and emits one 2-bit coded symbol per bit. It terminates every frame with two zero tail bits so the trellis returns to S0, which is the start state the decoder's PMU initialises to.

Parameters:
LEN_WIDTH, 8, width of frame length (info bits per frame, 0..2^LEN_WIDTH-1)
G0, 3'b111, generator polynomial for sym_o[1] (octal 7); bit2 = current input, bit1 = state[1], bit0 = state[0]
G1, 3'b101, generator polynomial for sym_o[0] (octal 5), same bit mapping

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  frame start pulse; sampled only in IDLE
frame_len_i  input  LEN_WIDTH  info-bit count for the frame; latched with start_i
bit_i  input  1  information bit
bit_valid_i  input  1  bit_i valid
bit_ready_o  output  1  encoder accepts bit_i this cycle
sym_o  output  2  coded symbol {c0,c1}
sym_valid_o  output  1  sym_o valid
sym_ready_i  input  1  downstream accepts sym_o
sym_last_o  output  1  marks the final tail symbol of the frame
busy_o  output  1  high whenever the FSM is not in IDLE
done_o  output  1  one-cycle pulse when the last symbol is handshaken

Behaviour:
- Encoder state is sreg[1:0]. sreg[1] is the newest past bit and sreg[0] the older one. Next state = {u, sreg[1]}. This matches the decoder trellis: S0->S0/S2, S1->S0/S2, S2->S1/S3, S3->S1/S3.
- c0 = ^({u,sreg} & G0); c1 = ^({u,sreg} & G1); sym_o = {c0,c1}.
- Reset (async, active-high) clears everything:
  - FSM to IDLE, sreg = 00, remaining-bit counter = 0, tail counter = 0.
  - sym_o = 00; sym_valid_o, sym_last_o, bit_ready_o, busy_o, done_o all 0.
- Output register: single stage. can_load = !sym_valid_o || sym_ready_i.
  - When a symbol is loaded, sym_valid_o rises the next cycle.
  - sym_o and sym_last_o hold stable while sym_valid_o=1 and sym_ready_i=0.
- FSM states:
  - IDLE: bit_ready_o=0. On start_i, latch frame_len_i and clear sreg to 00. Go to DATA if len>0, else TAIL. Set busy_o next cycle.
  - DATA: bit_ready_o = can_load (combinational).
    - A bit is accepted when bit_valid_i && bit_ready_o.
    - On accept: load its symbol, update sreg, decrement the counter.
    - When the last bit is accepted, go to TAIL with tail counter = 2.
  - TAIL: bit_ready_o=0. Each cycle with can_load=1, encode u=0.
    - The second tail symbol loads with sym_last_o=1; the FSM then goes to DRAIN.
  - DRAIN: wait for sym_valid_o && sym_ready_i && sym_last_o. In that cycle, pulse done_o for one cycle (registered, next cycle) and return to IDLE.
- Latency: an accepted bit produces its symbol on sym_o the following cycle. Full throughput is one symbol per cycle with sym_ready_i held high.
- Per frame, the block emits exactly frame_len+2 symbols, and sreg = 00 after the last tail bit.
- start_i outside IDLE is ignored; frame_len_i changes outside IDLE have no effect.
- bit_valid_i in IDLE, TAIL or DRAIN is not consumed: bit_ready_o=0.
- Reset mid-frame: the frame is abandoned, and no symbol, sym_last_o or done_o follows.
- Frames are back-to-back capable: start_i may be asserted the cycle after done_o.

Test Plan:
- len=4, bits 1,0,1,1, sym_ready_i=1 -> sym_o sequence 11,10,00,01,01,11 on consecutive cycles; sym_last_o only on the 6th; done_o pulses once; busy_o falls with done_o.
- len=3, bits 1,1,1 -> 11,01,10,01,11; final sreg=00.
- Backpressure: same frame as test 1, with sym_ready_i=0 for 3 cycles after the first symbol -> sym_o holds 11 and sym_valid_o stays 1; bit_ready_o=0; no bit lost; the output sequence is unchanged.
- len=0 -> exactly two symbols 00,00; sym_last_o on the second; done_o pulses.
- start_i asserted while busy with a different frame_len_i -> ignored; the current frame completes with the original length.
- rst_i asserted after 2 symbols of a len=4 frame -> all outputs 0 the same cycle (async); no sym_last_o or done_o; the next frame after reset encodes from sreg=00 with correct symbols.
